// File: rtl/io_uart_tx_pkg.sv
// Shared types and constants for the I/O hub UART transmitter:
// serializer states, register offsets and STATUS bit positions.
package selen_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/io_uart_tx_if.sv
// Wishbone-style io_* responder channel between the interconnect and the UART.
interface io_uart_tx_if;
  logic        io_stb_i;
  logic        io_we_i;
  logic [31:0] io_addr_i;
  logic [31:0] io_data_i;
  logic [31:0] io_data_o;
  logic        io_ack_o;

  modport master (
    output io_stb_i, io_we_i, io_addr_i, io_data_i,
    input  io_data_o, io_ack_o
  );

  modport slave (
    input  io_stb_i, io_we_i, io_addr_i, io_data_i,
    output io_data_o, io_ack_o
  );
endinterface

// File: rtl/io_uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push into a full FIFO succeeds when a pop
// happens on the same edge.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/io_uart_tx.sv
// UART 8N1 transmitter with a Wishbone responder front end: TXDATA pushes
// into a FIFO, STATUS reports FIFO/line state, the serializer drains to tx.
module io_uart_tx
  import selen_uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  io_uart_tx_if.slave  io,
  output logic         tx
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

  function automatic logic [3:0] sat_count(input logic [CNT_W-1:0] c);
    if (int'(c) > 15) return 4'hF;
    return 4'(c);
  endfunction

  logic             req;
  logic [1:0]       reg_sel;
  logic             wr_txdata;
  logic             wr_status;
  logic             rd_req;
  logic             overflow;
  logic             ovf_set;
  logic [7:0]       status;
  logic [31:0]      rd_data;
  logic             unused_bus;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_dout;
  logic             pop;

  tx_state_e        state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;

  assign unused_bus = ^{io.io_addr_i[31:4], io.io_addr_i[1:0], io.io_data_i[31:8]};

  // Bus decode: a request is live only in the cycle before its ack.
  assign req       = io.io_stb_i & ~io.io_ack_o;
  assign reg_sel   = io.io_addr_i[3:2];
  assign wr_txdata = req & io.io_we_i & (reg_sel == REG_TXDATA);
  assign wr_status = req & io.io_we_i & (reg_sel == REG_STATUS);
  assign rd_req    = req & ~io.io_we_i;
  assign ovf_set   = wr_txdata & fifo_full & ~pop;

  always_comb begin
    status                      = '0;
    status[STAT_FULL]           = fifo_full;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_BUSY]           = (state != ST_IDLE);
    status[STAT_OVF]            = overflow;
    status[STAT_CNT_LSB +: 4]   = sat_count(fifo_count);
  end

  assign rd_data = (rd_req && reg_sel == REG_STATUS) ? {24'd0, status} : 32'd0;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      io.io_ack_o  <= 1'b0;
      io.io_data_o <= '0;
      overflow     <= 1'b0;
    end else begin
      io.io_ack_o  <= req;
      io.io_data_o <= rd_data;
      if (ovf_set)        overflow <= 1'b1;
      else if (wr_status) overflow <= 1'b0;
    end
  end

  uart_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (wr_txdata),
    .din     (io.io_data_i[7:0]),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Serializer: each state/bit lasts CLK_DIV cycles, counted down to 0.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    pop       = 1'b0;
    tx_n      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          state_n = ST_START;
          baud_n  = BAUD_RELOAD;
        end
      end
      ST_START: begin
        if (baud == '0) begin
          state_n   = ST_DATA;
          bit_idx_n = 3'd0;
          baud_n    = BAUD_RELOAD;
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_dout;
            state_n = ST_START;
            baud_n  = BAUD_RELOAD;
          end else begin
            state_n = ST_IDLE;
            baud_n  = '0;
          end
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shreg_n[bit_idx_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a frame-timeline model checked every cycle,
// plus hand-computed line/status expectations.
module tb_io_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic tx;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .io      (bus.slave),
    .tx      (tx)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_req_edge = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte queue plus the cycle offset into the frame being sent.
  byte unsigned m_q[$];
  logic         m_busy;
  int           m_el;
  logic [7:0]   m_cur;
  logic         m_ack;
  logic [31:0]  m_rdata;
  logic         m_ovf;

  function automatic logic exp_tx();
    int pos;
    if (!m_busy) return 1'b1;
    pos = m_el / CLK_DIV;
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return m_cur[pos-1];
  endfunction

  always @(posedge sys_clk or negedge sys_rst) begin
    logic req, pop;
    int   sz;
    if (!sys_rst) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_el    = 0;
      m_cur   = 8'h00;
      m_ack   = 1'b0;
      m_rdata = 32'd0;
      m_ovf   = 1'b0;
    end else begin
      req = bus.io_stb_i & ~m_ack;
      sz  = m_q.size();
      pop = (sz > 0) && (!m_busy || m_el == FRAME - 1);
      m_rdata = 32'd0;
      if (req && !bus.io_we_i && bus.io_addr_i[3:2] == 2'd1)
        m_rdata = {24'd0, (sz > 15 ? 4'hF : 4'(sz)), m_ovf, m_busy, (sz == 0), (sz == DEPTH)};
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_busy = 1'b1;
        m_el   = 0;
      end else if (m_busy) begin
        m_el++;
        if (m_el == FRAME) m_busy = 1'b0;
      end
      if (req && bus.io_we_i && bus.io_addr_i[3:2] == 2'd0) begin
        if (sz < DEPTH || pop) m_q.push_back(bus.io_data_i[7:0]);
        else                   m_ovf = 1'b1;
      end
      if (req && bus.io_we_i && bus.io_addr_i[3:2] == 2'd1) m_ovf = 1'b0;
      m_ack = req;
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      check("model_tx",    {31'd0, tx},               {31'd0, exp_tx()});
      check("model_ack",   {31'd0, bus.io_ack_o},     {31'd0, m_ack});
      check("model_rdata", bus.io_data_o,             m_rdata);
    end
  end

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    int waited;
    @(negedge sys_clk);
    bus.io_stb_i  = 1'b1;
    bus.io_we_i   = we;
    bus.io_addr_i = addr;
    bus.io_data_i = wdata;
    last_req_edge = cyc + 1;
    waited = 0;
    do begin
      @(negedge sys_clk);
      waited++;
    end while (!bus.io_ack_o && waited < 8);
    check("ack_latency", waited, 1);
    rdata = bus.io_data_o;
    bus.io_stb_i = 1'b0;
    bus.io_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] d);
    logic [31:0] dummy;
    xfer(1'b1, addr, {24'd0, d}, dummy);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    xfer(1'b0, addr, 32'd0, d);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] st;
    logic [9:0]  a5_frame;
    int          e;
    int          acks;
    a5_frame = 10'b11_0100_1010;
    bus.io_stb_i  = 1'b0;
    bus.io_we_i   = 1'b0;
    bus.io_addr_i = 32'd0;
    bus.io_data_i = 32'd0;

    // Reset then idle
    repeat (3) @(negedge sys_clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("idle_tx",  {31'd0, tx}, 32'd1);
    check("idle_ack", {31'd0, bus.io_ack_o}, 32'd0);
    rd(32'h4, st);
    check("status_reset", st, 32'h02);
    rd(32'h0, st);
    check("txdata_read", st, 32'h00);
    rd(32'hC, st);
    check("reg3_read", st, 32'h00);

    // Single frame 0xA5
    wr(32'h0, 8'hA5);
    e = last_req_edge;
    check("a5_pre_start", {31'd0, tx}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      wait_cyc(e + 2 + CLK_DIV * k);
      check("a5_bit", {31'd0, tx}, {31'd0, a5_frame[k]});
    end
    wait_cyc(e + 1 + FRAME);
    check("a5_after_frame", {31'd0, tx}, 32'd1);
    wait_cyc(e + 45);
    rd(32'h4, st);
    check("status_after_a5", st, 32'h02);

    // Three back-to-back frames
    wr(32'h0, 8'h01);
    e = last_req_edge;
    wr(32'h0, 8'h80);
    wr(32'h0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      repeat (30) @(negedge sys_clk);
      rd(32'h4, st);
      check("b2b_busy", st & 32'h4, 32'h4);
    end
    wait_cyc(e + 3 * FRAME + 6);
    rd(32'h4, st);
    check("status_after_b2b", st, 32'h02);

    // Overflow: fill while sending, one drop, one same-edge accept
    wr(32'h0, 8'h11);
    e = last_req_edge;
    wr(32'h0, 8'h22);
    wr(32'h0, 8'h33);
    wr(32'h0, 8'h44);
    wr(32'h0, 8'h55);
    wr(32'h0, 8'h66);
    wait_cyc(e + FRAME - 1);
    wr(32'h0, 8'h77);
    rd(32'h4, st);
    check("status_overflow", st, 32'h4D);
    wr(32'h4, 8'h00);
    rd(32'h4, st);
    check("status_ovf_cleared", st, 32'h45);
    wait_cyc(e + 6 * FRAME + 10);
    rd(32'h4, st);
    check("status_after_ovf", st, 32'h02);

    // Strobe held through the ack cycle
    wr(32'h0, 8'h5A);
    @(negedge sys_clk);
    bus.io_stb_i  = 1'b1;
    bus.io_we_i   = 1'b1;
    bus.io_addr_i = 32'h0;
    bus.io_data_i = 32'hC3;
    acks = 0;
    @(negedge sys_clk);
    if (bus.io_ack_o) acks++;
    @(negedge sys_clk);
    if (bus.io_ack_o) acks++;
    bus.io_stb_i = 1'b0;
    bus.io_we_i  = 1'b0;
    @(negedge sys_clk);
    if (bus.io_ack_o) acks++;
    check("held_stb_acks", acks, 1);
    rd(32'h4, st);
    check("held_stb_count", st, 32'h14);
    repeat (2 * FRAME + 10) @(negedge sys_clk);
    rd(32'h4, st);
    check("status_after_held", st, 32'h02);

    // Reset during a data bit
    wr(32'h0, 8'h3C);
    e = last_req_edge;
    wait_cyc(e + 10);
    check("pre_reset_tx", {31'd0, tx}, 32'd0);
    #2 sys_rst = 1'b0;
    #1;
    check("async_reset_tx",    {31'd0, tx}, 32'd1);
    check("async_reset_ack",   {31'd0, bus.io_ack_o}, 32'd0);
    check("async_reset_rdata", bus.io_data_o, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (50) @(negedge sys_clk);
    check("post_reset_tx", {31'd0, tx}, 32'd1);
    rd(32'h4, st);
    check("status_after_reset", st, 32'h02);

    repeat (2) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
